// File: rtl/dir_key_queue.sv
// Four-key debounced direction input feeding a 2-deep move queue.
// Press pulses are ranked up > down > left > right; the winner is queued unless redundant, reversing or full.
module dir_key_deb #(
  parameter int DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);
  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

  logic          sync1, sync2, stable, stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key_raw;
      sync2    <= sync1;
      stable_d <= stable;
      // Pulse lands one cycle after the stable level falls
      press    <= stable_d & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module dir_key_queue #(
  parameter int DEB_CNT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       move_tick,
  output logic       left_key_press,
  output logic       right_key_press,
  output logic       up_key_press,
  output logic       down_key_press,
  output logic [1:0] dir,
  output logic [1:0] q_cnt,
  output logic       drop
);
  // Key index doubles as its direction code: 0 up, 1 down, 2 left, 3 right
  logic [3:0]      key_raw, press, cand_oh;
  logic [1:0][1:0] q;
  logic [1:0]      cand, ref_dir;
  logic            cand_vld, cand_rej, others, push, pop, wr_hi;

  assign key_raw = {right, left, down, up};

  generate
    for (genvar k = 0; k < 4; k++) begin : g_key
      dir_key_deb #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_raw(key_raw[k]),
        .press  (press[k])
      );
    end
  endgenerate

  assign up_key_press    = press[0];
  assign down_key_press  = press[1];
  assign left_key_press  = press[2];
  assign right_key_press = press[3];

  always_comb begin
    cand_vld = |press;
    cand_oh  = press & (~press + 4'd1);
    cand     = {cand_oh[2] | cand_oh[3], cand_oh[1] | cand_oh[3]};
    others   = |(press & ~cand_oh);
    ref_dir  = (q_cnt == 2'd2) ? q[1] : (q_cnt == 2'd1) ? q[0] : dir;
    pop      = move_tick && (q_cnt != 2'd0);
    // Same axis means equal or opposite direction
    cand_rej = cand_vld && ((cand[1] == ref_dir[1]) || (q_cnt == 2'd2 && !pop));
    push     = cand_vld && !cand_rej;
    wr_hi    = (q_cnt == 2'd2) || (q_cnt == 2'd1 && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir   <= 2'b11;
      q     <= '0;
      q_cnt <= 2'd0;
      drop  <= 1'b0;
    end else begin
      drop  <= cand_rej | others;
      q_cnt <= q_cnt + 2'(push) - 2'(pop);
      if (pop) begin
        dir  <= q[0];
        q[0] <= q[1];
      end
      if (push) begin
        if (wr_hi) q[1] <= cand;
        else       q[0] <= cand;
      end
    end
  end
endmodule

// File: tb/tb_dir_key_queue.sv
// Directed bench for dir_key_queue with DEB_CNT=4: table of press/release/tick steps plus timing and reset sequences.
module tb_dir_key_queue;
  logic       clk, rst_n, left, right, up, down, move_tick;
  logic       left_key_press, right_key_press, up_key_press, down_key_press, drop;
  logic [1:0] dir, q_cnt;

  int n_chk = 0;
  int n_fail = 0;

  dir_key_queue #(.DEB_CNT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .left           (left),
    .right          (right),
    .up             (up),
    .down           (down),
    .move_tick      (move_tick),
    .left_key_press (left_key_press),
    .right_key_press(right_key_press),
    .up_key_press   (up_key_press),
    .down_key_press (down_key_press),
    .dir            (dir),
    .q_cnt          (q_cnt),
    .drop           (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] keys;      // active-low {right,left,down,up}
    logic       tick;      // move_tick on the first cycle of the step
    int         ncyc;
    logic [3:0] exp_press; // keys that must pulse exactly once
    int         exp_drop;
    logic [1:0] exp_q;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    {right, left, down, up} = k;
  endtask

  task automatic do_reset(input logic [3:0] k);
    rst_n = 1'b0;
    move_tick = 1'b0;
    set_keys(k);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pc[4];
  int dc;

  task automatic count_pulses();
    pc[0] += int'(up_key_press);
    pc[1] += int'(down_key_press);
    pc[2] += int'(left_key_press);
    pc[3] += int'(right_key_press);
    dc    += int'(drop);
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 4; k++) pc[k] = 0;
    dc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    move_tick = 1'b0;
    set_keys(4'b1111);

    //            rst   keys     tick  n   press    drop q     dir
    vt[0]  = '{1'b1, 4'b1110, 1'b0, 10, 4'b0001, 0, 2'd1, 2'd3}; // up queued
    vt[1]  = '{1'b0, 4'b1111, 1'b0, 8,  4'b0000, 0, 2'd1, 2'd3};
    vt[2]  = '{1'b0, 4'b1011, 1'b0, 10, 4'b0100, 0, 2'd2, 2'd3}; // left queued
    vt[3]  = '{1'b0, 4'b1111, 1'b0, 8,  4'b0000, 0, 2'd2, 2'd3};
    vt[4]  = '{1'b0, 4'b1101, 1'b0, 10, 4'b0010, 1, 2'd2, 2'd3}; // down, queue full
    vt[5]  = '{1'b0, 4'b1111, 1'b0, 8,  4'b0000, 0, 2'd2, 2'd3};
    vt[6]  = '{1'b0, 4'b1111, 1'b1, 4,  4'b0000, 0, 2'd1, 2'd0}; // pop up
    vt[7]  = '{1'b0, 4'b1111, 1'b1, 4,  4'b0000, 0, 2'd0, 2'd2}; // pop left
    vt[8]  = '{1'b0, 4'b1111, 1'b1, 4,  4'b0000, 0, 2'd0, 2'd2}; // empty tick holds
    vt[9]  = '{1'b1, 4'b1011, 1'b0, 10, 4'b0100, 1, 2'd0, 2'd3}; // left vs right: opposite
    vt[10] = '{1'b0, 4'b1111, 1'b0, 8,  4'b0000, 0, 2'd0, 2'd3};
    vt[11] = '{1'b0, 4'b0111, 1'b0, 10, 4'b1000, 1, 2'd0, 2'd3}; // right vs right: same
    vt[12] = '{1'b0, 4'b1111, 1'b0, 8,  4'b0000, 0, 2'd0, 2'd3};
    vt[13] = '{1'b1, 4'b1010, 1'b0, 10, 4'b0101, 1, 2'd1, 2'd3}; // up+left together
    vt[14] = '{1'b0, 4'b1111, 1'b0, 8,  4'b0000, 0, 2'd1, 2'd3};
    vt[15] = '{1'b0, 4'b1111, 1'b1, 4,  4'b0000, 0, 2'd0, 2'd0}; // winner was up
    vt[16] = '{1'b0, 4'b1110, 1'b0, 10, 4'b0001, 1, 2'd0, 2'd0}; // up vs up: same
    vt[17] = '{1'b0, 4'b1111, 1'b0, 8,  4'b0000, 0, 2'd0, 2'd0};

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    chk("rst_dir", 32'(dir), 32'd3);
    chk("rst_q_cnt", 32'(q_cnt), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_press", 32'({up_key_press, down_key_press, left_key_press, right_key_press}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Press latency: pulse exactly 7 cycles after the first low sample
    set_keys(4'b1110);
    clr_counts();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      count_pulses();
      chk($sformatf("lat_up_c%0d", i), 32'(up_key_press), 32'(i == 7));
    end
    chk("lat_up_total", 32'(pc[0]), 32'd1);
    chk("lat_q_cnt", 32'(q_cnt), 32'd1);

    // Bounce: right toggles every 2 cycles, never stable long enough
    do_reset(4'b1111);
    clr_counts();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) right = ~right;
      @(negedge clk);
      count_pulses();
    end
    set_keys(4'b1111);
    chk("bounce_pulses", 32'(pc[0] + pc[1] + pc[2] + pc[3]), 32'd0);
    chk("bounce_q_cnt", 32'(q_cnt), 32'd0);

    // Table of press/release/tick steps
    for (int s = 0; s < 18; s++) begin
      if (vt[s].rst) do_reset(4'b1111);
      set_keys(vt[s].keys);
      move_tick = vt[s].tick;
      clr_counts();
      for (int c = 0; c < vt[s].ncyc; c++) begin
        @(negedge clk);
        move_tick = 1'b0;
        count_pulses();
      end
      for (int k = 0; k < 4; k++)
        chk($sformatf("v%0d_press%0d", s, k), 32'(pc[k]), 32'(vt[s].exp_press[k]));
      chk($sformatf("v%0d_drop", s), 32'(dc), 32'(vt[s].exp_drop));
      chk($sformatf("v%0d_q_cnt", s), 32'(q_cnt), 32'(vt[s].exp_q));
      chk($sformatf("v%0d_dir", s), 32'(dir), 32'(vt[s].exp_dir));
    end

    // Key held across reset release is a fresh press; push into empty queue with tick keeps dir
    do_reset(4'b1110);
    clr_counts();
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      count_pulses();
      chk($sformatf("held_up_c%0d", i), 32'(up_key_press), 32'(i == 7));
    end
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    chk("tick_push_q_cnt", 32'(q_cnt), 32'd1);
    chk("tick_push_dir", 32'(dir), 32'd3);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    chk("next_tick_dir", 32'(dir), 32'd0);
    chk("next_tick_q_cnt", 32'(q_cnt), 32'd0);

    // Async reset with a full queue and a half-counted key
    do_reset(4'b1111);
    set_keys(4'b1110); repeat (10) @(negedge clk);
    set_keys(4'b1111); repeat (8)  @(negedge clk);
    set_keys(4'b1011); repeat (10) @(negedge clk);
    set_keys(4'b1111); repeat (8)  @(negedge clk);
    chk("pre_rst_q_cnt", 32'(q_cnt), 32'd2);
    set_keys(4'b1101); repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_q_cnt", 32'(q_cnt), 32'd0);
    chk("async_dir", 32'(dir), 32'd3);
    set_keys(4'b1111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_counts();
    repeat (20) begin
      @(negedge clk);
      count_pulses();
    end
    chk("post_rst_pulses", 32'(pc[0] + pc[1] + pc[2] + pc[3] + dc), 32'd0);
    chk("post_rst_q_cnt", 32'(q_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dir_key_queue.md
DIR_KEY_QUEUE -- requirements
Module: dir_key_queue

Interface
REQ-001 The block SHALL have parameter DEB_CNT, default 1000000, meaning stable-level cycles required to accept a key change (20 ms at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1, system clock (50 MHz domain, same as game control).
REQ-003 The block SHALL have port rst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have ports left, right, up, down, input, 1 each, raw pushbutton levels, active-low, asynchronous to clk.
REQ-005 The block SHALL have port move_tick, input, 1, single-cycle pulse from the snake stepper marking one move step.
REQ-006 The block SHALL have ports left_key_press, right_key_press, up_key_press, down_key_press, output, 1 each, single-cycle debounced press pulses.
REQ-007 The block SHALL have port dir, output, 2, applied direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 The block SHALL have port q_cnt, output, 2, queued command count, 0..2.
REQ-009 The block SHALL have port drop, output, 1, single-cycle pulse when a candidate command is rejected.

Function
REQ-010 Each raw key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each key SHALL have a stable state register and a counter; the counter increments while the synced level differs from the stable state and clears whenever they are equal.
REQ-012 When the counter reaches DEB_CNT-1 and the levels still differ, the stable state SHALL take the synced level and the counter SHALL clear in the same cycle.
REQ-013 A stable transition 1->0 SHALL produce exactly one *_key_press pulse in the following cycle; a 0->1 transition SHALL produce none.
REQ-014 Press latency SHALL be 2 sync cycles + DEB_CNT cycles + 1 from the first cycle of a clean low level; bounces shorter than DEB_CNT cycles SHALL produce no pulse.
REQ-015 Simultaneous press pulses SHALL all be output; the queue candidate SHALL be the single highest-priority one (up > down > left > right), and each other pressed key SHALL count as rejected.
REQ-016 The reference direction SHALL be the queue tail entry if q_cnt>0, else dir.
REQ-017 A candidate SHALL be rejected if it equals the reference direction, is its opposite (up/down, left/right), or q_cnt==2 with no pop in that cycle.
REQ-018 drop SHALL pulse for one cycle whenever one or more candidates are rejected in a cycle.
REQ-019 The queue SHALL be a 2-entry FIFO; an accepted candidate is written at the tail, and q_cnt increments.
REQ-020 On move_tick with q_cnt>0, dir SHALL load the head entry and the entry SHALL be popped the same cycle; with q_cnt==0, dir SHALL hold.
REQ-021 Push and pop in the same cycle SHALL both occur and leave q_cnt unchanged; when full, a same-cycle pop SHALL make room for the push.
REQ-022 A push into an empty queue coincident with move_tick SHALL NOT change dir that cycle; the entry SHALL apply on the next move_tick.
REQ-023 q_cnt SHALL never exceed 2 or underflow below 0.

Reset
REQ-024 While rst_n=0: synchronizers and stable states SHALL be 1 (released), counters 0, queue empty (q_cnt=0), dir=11 (right), and all pulse outputs 0.
REQ-025 Reset asserted mid-debounce or with a non-empty queue SHALL discard all progress and entries immediately, with no pulse on release.
REQ-026 A key held low across reset release SHALL be treated as a fresh press, with its pulse after the normal REQ-014 latency.

Verification (DEB_CNT=4)
REQ-027 The bench SHALL drive up low for 10 cycles after reset and require exactly one up_key_press pulse 7 cycles after the first low sample, with q_cnt=1.
REQ-028 The bench SHALL toggle right low/high every 2 cycles for 40 cycles and require no press pulses and q_cnt=0.
REQ-029 The bench SHALL press up, then left, with no tick, and require q_cnt=2; it SHALL then press down and require one drop pulse with q_cnt=2; after two move_ticks, dir SHALL be 00 then 10.
REQ-030 With dir=11 and an empty queue, the bench SHALL press left and require one drop pulse with q_cnt=0; it SHALL then press right and require one drop pulse.
REQ-031 The bench SHALL press up and left so their stable transitions fall in the same cycle and require both press pulses, the enqueued entry to be 00, and one drop pulse.
REQ-032 The bench SHALL assert rst_n=0 with q_cnt=2 and a half-counted key and require q_cnt=0 and dir=11 asynchronously, before the next clk edge, with no pulses after release.
